// File: rtl/axis_in_fifo.sv
// axis_in_fifo: AXI-Stream slave front-end for the FIR dataflow.
// Buffers incoming samples in a DEPTH-entry first-word-fall-through FIFO.
// Each entry carries its own end-of-frame bit. Frame length is checked
// against a programmed value, and any mismatch is reported.
//
// State table
//   IDLE  | waiting for ap_start; upstream held off
//   RUN   | accepting samples until the final one of the frame
//   DRAIN | upstream held off; waiting for the final sample to be popped
//   DONE  | one-cycle axis_finish pulse, then back to IDLE
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   ap_start            frame start pulse (honoured only in IDLE)
//   data_length         samples per frame, 0 = ended by tlast only
//   ss_tvalid/tdata/tlast/tready   upstream AXI-Stream slave
//   strm_data/last/valid, fir_ready  downstream FIFO head and pop enable
//   axis_finish         pulse after the final sample has been popped
//   len_err             sticky frame-length mismatch flag
//   sample_cnt          samples accepted in the current frame
//   level               FIFO occupancy
module axis_in_fifo #(
    parameter int pDATA_WIDTH = 32,
    parameter int DEPTH       = 4,
    parameter int pCNT_WIDTH  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ap_start,
    input  logic [pCNT_WIDTH-1:0]      data_length,
    input  logic                       ss_tvalid,
    input  logic [pDATA_WIDTH-1:0]     ss_tdata,
    input  logic                       ss_tlast,
    output logic                       ss_tready,
    output logic [pDATA_WIDTH-1:0]     strm_data,
    output logic                       strm_last,
    output logic                       strm_valid,
    input  logic                       fir_ready,
    output logic                       axis_finish,
    output logic                       len_err,
    output logic [pCNT_WIDTH-1:0]      sample_cnt,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_nxt;

    logic [AW:0]              wr_ptr, rd_ptr;
    logic [pDATA_WIDTH-1:0]   mem_data [DEPTH];
    logic                     mem_last [DEPTH];

    logic                     full, empty, push, pop;
    logic [pCNT_WIDTH-1:0]    cnt_inc;
    logic                     len_hit, is_final, len_mismatch;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign push = ss_tvalid & ss_tready;
    assign pop  = strm_valid & fir_ready;

    assign cnt_inc      = sample_cnt + pCNT_WIDTH'(1);
    assign len_hit      = (data_length != '0) && (cnt_inc == data_length);
    assign is_final     = ss_tlast | len_hit;
    assign len_mismatch = (data_length != '0) && (ss_tlast != len_hit);

    assign strm_data  = mem_data[rd_ptr[AW-1:0]];
    assign strm_last  = mem_last[rd_ptr[AW-1:0]];
    assign strm_valid = ~empty;
    assign level      = wr_ptr - rd_ptr;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ap_start) state_nxt = RUN;
            RUN:     if (push && is_final) state_nxt = DRAIN;
            DRAIN:   if (pop && strm_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from registered state; ss_tready never looks at ss_tvalid.
    always_comb begin
        ss_tready   = 1'b0;
        axis_finish = 1'b0;
        case (state)
            RUN:     ss_tready   = ~full;
            DONE:    axis_finish = 1'b1;
            default: ;
        endcase
    end

    // FIFO storage and pointers. Reset clears the storage so the head reads 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_last[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr[AW-1:0]] <= ss_tdata;
                mem_last[wr_ptr[AW-1:0]] <= is_final;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Frame bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
            len_err    <= 1'b0;
        end else if (state == IDLE && ap_start) begin
            sample_cnt <= '0;
            len_err    <= 1'b0;
        end else if (push) begin
            sample_cnt <= cnt_inc;
            // tlast and the programmed length disagree on where the frame ends.
            if (is_final && len_mismatch) len_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_in_fifo.sv
module tb_axis_in_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ap_start = 1'b0;
    logic [31:0] data_length = '0;
    logic        ss_tvalid = 1'b0;
    logic [31:0] ss_tdata = '0;
    logic        ss_tlast = 1'b0;
    logic        ss_tready;
    logic [31:0] strm_data;
    logic        strm_last;
    logic        strm_valid;
    logic        fir_ready = 1'b0;
    logic        axis_finish;
    logic        len_err;
    logic [31:0] sample_cnt;
    logic [2:0]  level;

    int errors = 0;
    int checks = 0;

    // results of the last stream() call
    int t_sent, t_pops, t_fins, t_fin_ok;

    axis_in_fifo #(.pDATA_WIDTH(32), .DEPTH(4), .pCNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .ap_start(ap_start), .data_length(data_length),
        .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
        .ss_tready(ss_tready), .strm_data(strm_data), .strm_last(strm_last),
        .strm_valid(strm_valid), .fir_ready(fir_ready), .axis_finish(axis_finish),
        .len_err(len_err), .sample_cnt(sample_cnt), .level(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_frame(input logic [31:0] len);
        data_length = len;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
    endtask

    // Offers samples first..n (data = index, tlast at index tlast_at) with
    // fir_ready=1, checks every pop against pop_first.. with strm_last only at
    // last_at, and records whether axis_finish pulses exactly one cycle after
    // the final pop.
    task automatic stream(input int first, input int n, input int tlast_at,
                          input int pop_first, input int last_at, input int budget);
        int k, p, pop_cyc, fin_cyc;
        k = first; p = pop_first; pop_cyc = -10; fin_cyc = -10;
        t_sent = 0; t_pops = 0; t_fins = 0; t_fin_ok = 0;
        fir_ready = 1'b1;
        for (int c = 0; c < budget; c++) begin
            ss_tvalid = (k <= n);
            ss_tdata  = k;
            ss_tlast  = (k == tlast_at);
            #1;
            if (strm_valid && fir_ready) begin
                chk("pop_data", strm_data, p);
                chk("pop_last", strm_last, (p == last_at));
                if (strm_last) pop_cyc = c;
                p++;
                t_pops++;
            end
            if (axis_finish) begin
                t_fins++;
                fin_cyc = c;
                if (c == pop_cyc + 1) t_fin_ok = 1;
            end
            if (ss_tvalid && ss_tready) begin
                k++;
                t_sent++;
            end
            if (t_fins > 0 && c >= fin_cyc + 2) break;
            tick();
        end
        ss_tvalid = 1'b0;
        ss_tlast  = 1'b0;
    endtask

    initial begin
        int acc;

        // 1: reset / idle
        @(negedge clk);
        rst = 1'b1;
        ss_tvalid = 1'b1;
        #1;
        chk("rst_tready", ss_tready, 0);
        chk("rst_valid", strm_valid, 0);
        chk("rst_data", strm_data, 0);
        chk("rst_last", strm_last, 0);
        chk("rst_finish", axis_finish, 0);
        chk("rst_lenerr", len_err, 0);
        chk("rst_cnt", sample_cnt, 0);
        chk("rst_level", level, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("idle_tready", ss_tready, 0);
        chk("idle_level", level, 0);
        ss_tvalid = 1'b0;

        // 2: nominal 11-sample frame
        start_frame(32'd11);
        chk("run_tready", ss_tready, 1);
        stream(1, 11, 11, 1, 11, 60);
        chk("nom_sent", t_sent, 11);
        chk("nom_pops", t_pops, 11);
        chk("nom_fins", t_fins, 1);
        chk("nom_fin_timing", t_fin_ok, 1);
        chk("nom_lenerr", len_err, 0);
        chk("nom_cnt", sample_cnt, 11);

        // 3: backpressure with a 6-sample frame
        start_frame(32'd6);
        fir_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            ss_tvalid = 1'b1;
            ss_tdata  = acc + 1;
            ss_tlast  = 1'b0;
            #1;
            if (ss_tready) acc++;
            tick();
        end
        chk("bp_accepts", acc, 4);
        chk("bp_level_full", level, 4);
        chk("bp_tready_full", ss_tready, 0);
        chk("bp_head", strm_data, 1);
        ss_tdata = 32'd5;
        fir_ready = 1'b1;
        #1;
        chk("bp_tready_popcyc", ss_tready, 0);
        tick();
        fir_ready = 1'b0;
        #1;
        chk("bp_level_after_pop", level, 3);
        chk("bp_tready_reopen", ss_tready, 1);
        tick();
        chk("bp_level_refill", level, 4);
        chk("bp_cnt", sample_cnt, 5);
        stream(6, 6, 6, 2, 6, 60);
        chk("bp_sent", t_sent, 1);
        chk("bp_pops", t_pops, 5);
        chk("bp_fins", t_fins, 1);
        chk("bp_lenerr", len_err, 0);

        // 4: short frame: length 8, tlast on 5th
        start_frame(32'd8);
        stream(1, 8, 5, 1, 5, 60);
        chk("short_sent", t_sent, 5);
        chk("short_pops", t_pops, 5);
        chk("short_fins", t_fins, 1);
        chk("short_lenerr", len_err, 1);
        chk("short_cnt", sample_cnt, 5);

        // 5: long frame: length 3, tlast never
        start_frame(32'd3);
        chk("lenerr_cleared", len_err, 0);
        stream(1, 4, 0, 1, 3, 60);
        chk("long_sent", t_sent, 3);
        chk("long_pops", t_pops, 3);
        chk("long_fins", t_fins, 1);
        chk("long_lenerr", len_err, 1);

        // 6: unbounded frame aborted by reset, then a clean 2-sample frame
        start_frame(32'd0);
        chk("unb_lenerr_cleared", len_err, 0);
        fir_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            ss_tvalid = 1'b1;
            ss_tdata  = 32'h100 + acc;
            ss_tlast  = 1'b0;
            #1;
            if (ss_tready) acc++;
            tick();
        end
        chk("unb_accepts", acc, 4);
        chk("unb_cnt", sample_cnt, 4);
        chk("unb_level", level, 4);
        rst = 1'b1;
        #1;
        chk("abort_level", level, 0);
        chk("abort_valid", strm_valid, 0);
        chk("abort_tready", ss_tready, 0);
        chk("abort_cnt", sample_cnt, 0);
        tick();
        rst = 1'b0;
        ss_tvalid = 1'b0;
        tick();
        chk("abort_idle_tready", ss_tready, 0);
        start_frame(32'd0);
        stream(1, 2, 2, 1, 2, 40);
        chk("clean_sent", t_sent, 2);
        chk("clean_pops", t_pops, 2);
        chk("clean_fins", t_fins, 1);
        chk("clean_fin_timing", t_fin_ok, 1);
        chk("clean_lenerr", len_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
